decrement_timer_ctrl: RTL and testbench

Countdown sequencer built around the 20-bit `decrement_module`. It loads a count and steps the count through the decrementer once per prescaled tick. It raises a one-cycle `expire` pulse when the count reaches zero, and can optionally auto-reload. It sits beside the URCPU core as its programmable delay/repeat timer. It is the only driver of its `decrement_module` instance.

---
 rtl/decrement_timer_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_decrement_timer_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decrement_timer_ctrl.sv
// -----------------------------------------------------------------------------
// decrement_timer_ctrl
//
// Programmable countdown timer that sits beside the URCPU core. A count is
// loaded and then stepped down through a dedicated decrementer once per
// prescaled tick. When the count reaches zero a one-cycle expire pulse is
// raised. The timer then either stops or, with auto-reload, restarts from the
// reload register.
//
// Contents of this file:
//   decrement_module      - combinational WIDTH-bit decrement with borrow flag
//   decrement_timer_ctrl  - IDLE/RUN sequencer, prescaler and output registers
//
// decrement_timer_ctrl ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   load         in   write load_value into count and reload
//   load_value   in   [WIDTH-1:0] value to load
//   start        in   begin/resume counting
//   stop         in   pause counting (count retained); wins over start
//   auto_reload  in   reload count from reload register at expiry
//   prescale     in   [PRE_W-1:0] one decrement every prescale+1 cycles
//   count        out  [WIDTH-1:0] current count (registered)
//   busy         out  high while in RUN (registered)
//   expire       out  one-cycle expiry pulse (registered)
// -----------------------------------------------------------------------------

module decrement_module #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
);

  // out = in - 1 modulo 2^WIDTH; borrow only when the input is zero
  assign out       = in - {{(WIDTH-1){1'b0}}, 1'b1};
  assign carry_out = (in == {WIDTH{1'b0}});

endmodule

module decrement_timer_ctrl #(
  parameter int WIDTH = 20,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PRE_W-1:0] pre_q,    pre_d;
  logic             busy_q,   busy_d;
  logic             expire_q, expire_d;

  logic [WIDTH-1:0] dec_out_s;
  logic             dec_carry_s;
  logic [WIDTH-1:0] start_count_s;

  // The decrementer always looks at the current count; this block is its only driver.
  decrement_module #(
    .WIDTH (WIDTH)
  ) u_dec (
    .in        (count_q),
    .out       (dec_out_s),
    .carry_out (dec_carry_s)
  );

  // Count that a start in IDLE would run from: a same-cycle load takes effect first.
  assign start_count_s = load ? load_value : count_q;

  // Next-state, next-count, prescaler and expire logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    expire_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          count_d  = load_value;
          reload_d = load_value;
        end else begin
          count_d  = count_q;
          reload_d = reload_q;
        end

        if (start && !stop) begin
          if (start_count_s != {WIDTH{1'b0}}) begin
            state_d = RUN;
            pre_d   = prescale;
          end else begin
            // Nothing to count: report expiry immediately and stay idle.
            expire_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (stop) begin
          // Pause; pre is re-armed on the next start so it is left alone here.
          state_d = IDLE;
        end else if (load) begin
          // A load replaces this cycle's tick entirely.
          count_d  = load_value;
          reload_d = load_value;
          pre_d    = prescale;
          if (load_value == {WIDTH{1'b0}}) begin
            state_d  = IDLE;
            expire_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else if (pre_q != {PRE_W{1'b0}}) begin
          pre_d = pre_q - {{(PRE_W-1){1'b0}}, 1'b1};
        end else begin
          // Tick.
          pre_d = prescale;
          if (dec_carry_s) begin
            // Unreachable through normal control; park safely without expiry.
            state_d = IDLE;
            count_d = {WIDTH{1'b0}};
          end else if (dec_out_s == {WIDTH{1'b0}}) begin
            expire_d = 1'b1;
            if (auto_reload && (reload_q != {WIDTH{1'b0}})) begin
              count_d = reload_q;
              state_d = RUN;
            end else begin
              count_d = dec_out_s;
              state_d = IDLE;
            end
          end else begin
            count_d = dec_out_s;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= {WIDTH{1'b0}};
      reload_q <= {WIDTH{1'b0}};
      pre_q    <= {PRE_W{1'b0}};
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      busy_q   <= busy_d;
      expire_q <= expire_d;
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign expire = expire_q;

endmodule

// File: tb/tb_decrement_timer_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for decrement_timer_ctrl. The stimulus process drives inputs, runs
// a behavioural timer model on the inputs seen at each rising edge and queues
// the expected outputs. A monitor on the falling edge pops the queue and
// compares against the DUT.
// -----------------------------------------------------------------------------

module tb_decrement_timer_ctrl;

  localparam int WIDTH = 20;
  localparam int PRE_W = 8;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expire;

  decrement_timer_ctrl #(
    .WIDTH (WIDTH),
    .PRE_W (PRE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .count       (count),
    .busy        (busy),
    .expire      (expire)
  );

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expire;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Model state: whether counting, the count, the reload value, and the number
  // of cycles still to wait before the next decrement.
  bit          m_run  = 1'b0;
  int unsigned m_cnt  = 0;
  int unsigned m_rel  = 0;
  int          m_wait = 0;
  bit          m_exp  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one rising edge of timer behaviour to the model.
  task automatic model_step();
    m_exp = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_cnt = 0; m_rel = 0; m_wait = 0;
    end else if (!m_run) begin
      if (load) begin
        m_cnt = load_value;
        m_rel = load_value;
      end
      if (start && !stop) begin
        if (m_cnt != 0) begin
          m_run  = 1'b1;
          m_wait = int'(prescale) + 1;
        end else begin
          m_exp = 1'b1;
        end
      end
    end else begin
      if (stop) begin
        m_run = 1'b0;
      end else if (load) begin
        m_cnt  = load_value;
        m_rel  = load_value;
        m_wait = int'(prescale) + 1;
        if (load_value == 0) begin
          m_run = 1'b0;
          m_exp = 1'b1;
        end
      end else begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_wait = int'(prescale) + 1;
          m_cnt  = m_cnt - 1;
          if (m_cnt == 0) begin
            m_exp = 1'b1;
            if (auto_reload && m_rel != 0) m_cnt = m_rel;
            else m_run = 1'b0;
          end
        end
      end
    end
  endtask

  // One clock cycle: inputs already set by the caller are sampled at the edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    e.count  = m_cnt[WIDTH-1:0];
    e.busy   = m_run;
    e.expire = m_exp;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (count === e.count) passed++;
      else $display("FAIL count @%0t: got %h want %h", $time, count, e.count);
      checks++;
      if (busy === e.busy) passed++;
      else $display("FAIL busy @%0t: got %b want %b", $time, busy, e.busy);
      checks++;
      if (expire === e.expire) passed++;
      else $display("FAIL expire @%0t: got %b want %b", $time, expire, e.expire);
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; prescale = '0;

    // Reset, then idle.
    cycles(2);
    rst = 1'b0;
    cycles(5);

    // Basic countdown, prescale 0.
    load = 1'b1; load_value = 20'd3; prescale = 8'd0; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycles(6);

    // Prescaled countdown.
    load = 1'b1; load_value = 20'd2; prescale = 8'd2; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycles(10);

    // Auto-reload, then drop it.
    auto_reload = 1'b1; load = 1'b1; load_value = 20'd2; prescale = 8'd0; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycles(8);
    auto_reload = 1'b0; cycles(4);

    // Stop / start+stop / resume.
    load = 1'b1; load_value = 20'd5; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycles(2);
    stop = 1'b1; cycle();
    stop = 1'b0; cycles(4);
    start = 1'b1; stop = 1'b1; cycle();
    start = 1'b0; stop = 1'b0; cycle();
    start = 1'b1; cycle();
    start = 1'b0; cycles(5);

    // Start with zero count, then maximum count.
    load = 1'b1; load_value = 20'd0; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycles(3);
    load = 1'b1; load_value = 20'hFFFFF; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycles(3);
    // Load during RUN, including a zero load.
    load = 1'b1; load_value = 20'd4; cycle();
    load = 1'b0; cycles(2);
    load = 1'b1; load_value = 20'd0; cycle();
    load = 1'b0; cycles(2);

    // Reset mid-run.
    load = 1'b1; load_value = 20'd7; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycles(2);
    rst = 1'b1; start = 1'b1; load = 1'b1; cycle();
    rst = 1'b0; start = 1'b0; load = 1'b0; cycles(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(199, 0) == 0);
      load        = ($urandom_range(9, 0) == 0);
      load_value  = ($urandom_range(15, 0) == 0) ? 20'($urandom) : 20'($urandom_range(6, 0));
      start       = ($urandom_range(3, 0) == 0);
      stop        = ($urandom_range(11, 0) == 0);
      prescale    = 8'($urandom_range(3, 0));
      if ($urandom_range(29, 0) == 0) auto_reload = ~auto_reload;
      cycle();
    end
    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
